program_counter_stack: RTL and testbench

//   Parametrised next-generation program counter for the sequencer. Adds a hardware

---
 rtl/program_counter_stack.sv | 151 +++++++++++++++
 tb/tb_program_counter_stack.sv | 121 ++++++++++++
 2 files changed

// File: rtl/program_counter_stack.sv
// program_counter_stack
//   Sequencer program counter with increment, absolute jump and a hardware
//   return-address stack for CALL/RET. The reset vector is configurable.
//   stack_err is a sticky flag for illegal stack use. It is set by a call on a
//   full stack or by a ret on an empty stack.
//
// Ports
//   clk         in   system clock; all state changes on the rising edge
//   rst         in   synchronous, active-high reset
//   pc_inc      in   advance add by 1 (wraps modulo 2**ADDR_W)
//   jmp         in   load add with jmp_add
//   call        in   push add+1, load add with jmp_add
//   ret         in   pop top of stack into add
//   jmp_add     in   jump/call target
//   add         out  current program address (registered)
//   sp          out  number of valid stack entries (registered)
//   stack_full  out  sp == STACK_DEPTH
//   stack_empty out  sp == 0
//   stack_err   out  sticky overflow/underflow flag (registered)
//
// Priority per cycle: rst > jmp > call > ret > pc_inc. Only one action is taken.

module program_counter_stack #(
    parameter int unsigned            ADDR_W      = 5,
    parameter int unsigned            STACK_DEPTH = 4,
    parameter logic [ADDR_W-1:0]      RESET_ADDR  = '0,
    localparam int unsigned           SP_W        = $clog2(STACK_DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              pc_inc,
    input  logic              jmp,
    input  logic              call,
    input  logic              ret,
    input  logic [ADDR_W-1:0] jmp_add,
    output logic [ADDR_W-1:0] add,
    output logic [SP_W-1:0]   sp,
    output logic              stack_full,
    output logic              stack_empty,
    output logic              stack_err
);

    // Index width for the stack array; at least one bit even for a single entry.
    localparam int unsigned IDX_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

    typedef enum logic [2:0] {
        ActHold,
        ActJmp,
        ActCall,
        ActRet,
        ActInc
    } action_e;

    logic [ADDR_W-1:0] add_q, add_d;
    logic [SP_W-1:0]   sp_q, sp_d;
    logic              err_q, err_d;

    logic [ADDR_W-1:0] stack_q [STACK_DEPTH];
    logic              push;
    logic [IDX_W-1:0]  push_idx;
    logic [IDX_W-1:0]  pop_idx;
    logic [SP_W-1:0]   sp_dec;
    logic [ADDR_W-1:0] add_inc;
    logic              full;
    logic              empty;
    action_e           action;

    assign full    = (sp_q == SP_W'(STACK_DEPTH));
    assign empty   = (sp_q == '0);
    assign add_inc = add_q + ADDR_W'(1);
    assign sp_dec  = sp_q - SP_W'(1);

    // sp is below STACK_DEPTH whenever a push happens and above zero whenever
    // a pop happens, so truncating to the array index width is lossless.
    assign push_idx = sp_q[IDX_W-1:0];
    assign pop_idx  = sp_dec[IDX_W-1:0];

    // Priority decode of the controls. Reset is handled in the register block.
    always_comb begin
        action = ActHold;
        if (jmp) begin
            action = ActJmp;
        end else if (call) begin
            action = ActCall;
        end else if (ret) begin
            action = ActRet;
        end else if (pc_inc) begin
            action = ActInc;
        end
    end

    always_comb begin
        add_d = add_q;
        sp_d  = sp_q;
        err_d = err_q;
        push  = 1'b0;
        unique case (action)
            ActJmp: begin
                add_d = jmp_add;
            end
            ActCall: begin
                if (full) begin
                    // Overflow: leave address and stack alone, just flag it.
                    err_d = 1'b1;
                end else begin
                    push  = 1'b1;
                    sp_d  = sp_q + SP_W'(1);
                    add_d = jmp_add;
                end
            end
            ActRet: begin
                if (empty) begin
                    err_d = 1'b1;
                end else begin
                    sp_d  = sp_dec;
                    add_d = stack_q[pop_idx];
                end
            end
            ActInc: begin
                add_d = add_inc;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            add_q <= RESET_ADDR;
            sp_q  <= '0;
            err_q <= 1'b0;
        end else begin
            add_q <= add_d;
            sp_q  <= sp_d;
            err_q <= err_d;
        end
    end

    // Stack contents are not reset; sp alone defines which entries are valid.
    always_ff @(posedge clk) begin
        if (!rst && push) begin
            stack_q[push_idx] <= add_inc;
        end
    end

    assign add         = add_q;
    assign sp          = sp_q;
    assign stack_err   = err_q;
    assign stack_full  = full;
    assign stack_empty = empty;

endmodule

// File: tb/tb_program_counter_stack.sv
module tb_program_counter_stack;

    localparam int unsigned ADDR_W = 5;
    localparam int unsigned DEPTH  = 4;
    localparam int unsigned SP_W   = $clog2(DEPTH + 1);

    logic              clk = 1'b0;
    logic              rst, pc_inc, jmp, call, ret;
    logic [ADDR_W-1:0] jmp_add;
    logic [ADDR_W-1:0] add, add5;
    logic [SP_W-1:0]   sp, sp5;
    logic              stack_full, stack_empty, stack_err;
    logic              full5, empty5, err5;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    program_counter_stack #(
        .ADDR_W(ADDR_W), .STACK_DEPTH(DEPTH), .RESET_ADDR(5'd0)
    ) dut (
        .clk(clk), .rst(rst), .pc_inc(pc_inc), .jmp(jmp), .call(call), .ret(ret),
        .jmp_add(jmp_add), .add(add), .sp(sp), .stack_full(stack_full),
        .stack_empty(stack_empty), .stack_err(stack_err)
    );

    program_counter_stack #(
        .ADDR_W(ADDR_W), .STACK_DEPTH(DEPTH), .RESET_ADDR(5'd5)
    ) dut5 (
        .clk(clk), .rst(rst), .pc_inc(pc_inc), .jmp(jmp), .call(call), .ret(ret),
        .jmp_add(jmp_add), .add(add5), .sp(sp5), .stack_full(full5),
        .stack_empty(empty5), .stack_err(err5)
    );

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    // Apply one cycle of controls; outputs are sampled 1 time unit after the edge.
    task automatic op(input logic r, input logic i, input logic j, input logic c,
                      input logic t, input logic [ADDR_W-1:0] a);
        rst = r; pc_inc = i; jmp = j; call = c; ret = t; jmp_add = a;
        @(posedge clk);
        #1;
        rst = 0; pc_inc = 0; jmp = 0; call = 0; ret = 0; jmp_add = '0;
    endtask

    task automatic st(input string tag, input int ea, input int es, input int ee);
        check({tag, ".add"}, int'(add), ea);
        check({tag, ".sp"},  int'(sp), es);
        check({tag, ".err"}, int'(stack_err), ee);
    endtask

    initial begin
        rst = 0; pc_inc = 0; jmp = 0; call = 0; ret = 0; jmp_add = '0;
        @(negedge clk);

        // 1 reset + increment
        op(1, 0, 0, 0, 0, 0);
        st("rst", 0, 0, 0);
        check("rst.empty", int'(stack_empty), 1);
        check("rst.full", int'(stack_full), 0);
        op(0, 1, 0, 0, 0, 0); check("inc1", int'(add), 1);
        op(0, 1, 0, 0, 0, 0); check("inc2", int'(add), 2);
        op(0, 1, 0, 0, 0, 0); st("inc3", 3, 0, 0);
        op(0, 0, 0, 0, 0, 0); st("hold", 3, 0, 0);

        // 2 wrap
        op(0, 0, 1, 0, 0, 31); check("jmp31", int'(add), 31);
        op(0, 1, 0, 0, 0, 0);  st("wrap", 0, 0, 0);

        // 3 nested call/ret
        op(0, 0, 1, 0, 0, 3);
        op(0, 0, 0, 1, 0, 10); st("call10", 10, 1, 0);
        op(0, 0, 0, 1, 0, 20); st("call20", 20, 2, 0);
        op(0, 0, 0, 0, 1, 0);  st("ret1", 11, 1, 0);
        op(0, 0, 0, 0, 1, 0);  st("ret2", 4, 0, 0);

        // 4 overflow
        op(0, 0, 1, 0, 0, 0);
        for (int k = 0; k < 4; k++) op(0, 0, 0, 1, 0, 8);
        st("fill", 8, 4, 0);
        check("fill.full", int'(stack_full), 1);
        op(0, 0, 0, 1, 0, 16); st("ovf", 8, 4, 1);
        op(0, 0, 0, 0, 1, 0);  st("pop1", 9, 3, 1);
        op(0, 0, 0, 0, 1, 0);  st("pop2", 9, 2, 1);
        op(0, 0, 0, 0, 1, 0);  st("pop3", 9, 1, 1);
        op(0, 0, 0, 0, 1, 0);  st("pop4", 1, 0, 1);
        check("pop4.empty", int'(stack_empty), 1);

        // 5 underflow and priority
        op(1, 0, 0, 0, 0, 0);  st("rst5", 0, 0, 0);
        op(0, 0, 0, 0, 1, 0);  st("unf", 0, 0, 1);
        op(0, 0, 1, 1, 1, 7);  st("jcr", 7, 0, 1);
        op(0, 0, 0, 1, 1, 12); st("cr", 12, 1, 1);
        op(0, 0, 0, 0, 1, 0);  st("cr.ret", 8, 0, 1);
        op(0, 1, 1, 0, 0, 2);  st("j_over_inc", 2, 0, 1);

        // 6 reset mid-operation
        op(1, 0, 0, 0, 0, 0);
        op(0, 0, 0, 0, 1, 0);  check("pre.err", int'(stack_err), 1);
        op(0, 0, 0, 1, 0, 1);
        op(0, 0, 0, 1, 0, 2);
        op(0, 0, 0, 1, 0, 3);  st("sp3", 3, 3, 1);
        op(1, 1, 0, 1, 0, 9);  st("midrst", 0, 0, 0);
        check("midrst.add5", int'(add5), 5);
        check("midrst.sp5", int'(sp5), 0);
        op(0, 1, 0, 0, 0, 0);
        check("after.add", int'(add), 1);
        check("after.add5", int'(add5), 6);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
